// File: rtl/rr_grant_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter4
//   Four-requester round-robin arbiter feeding a 2-to-4 decoder. One owner is
//   granted at a time. A grant is held until the owner pulses done, drops its
//   request, or reaches MAX_HOLD cycles. A dead gap of GAP_CYCLES cycles (plus
//   the arbitration edge) follows every grant, so decoder outputs can settle.
//
// Parameters
//   MAX_HOLD    max cycles grant_en stays high for one owner (2..255)
//   GAP_CYCLES  cycles grant_en is held low after a release (1..7)
//
// Ports
//   clk         in   clock, all state updates on posedge
//   reset       in   synchronous active-high reset
//   req[3:0]    in   level request, bit i = requester i
//   done[3:0]   in   one-cycle completion pulse, only the owner's bit matters
//   grant_addr  out  index of current/last owner (decoder address)
//   grant_en    out  grant active (decoder enable)
//   busy        out  high whenever the arbiter is not idle
//   timeout     out  one-cycle pulse when a grant is revoked by the hold limit
// ---------------------------------------------------------------------------
module rr_grant_arbiter4 #(
  parameter int MAX_HOLD   = 15,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [1:0] grant_addr,
  output logic       grant_en,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [2:0] r_gap_cnt;
  logic [1:0] r_grant_addr;
  logic       r_grant_en;
  logic       r_busy;
  logic       r_timeout;

  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_done_own;
  logic       w_req_lost;
  logic       w_hold_hit;
  logic       w_release;
  logic       w_gap_last;

  // Round-robin search: walk offsets from the far end down to zero so the
  // requester closest to r_ptr (offset 0 first) is the last one written.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_done_own = done[r_grant_addr];
  assign w_req_lost = ~req[r_grant_addr];
  assign w_hold_hit = (r_hold_cnt == 8'(MAX_HOLD - 1));
  assign w_release  = w_done_own | w_req_lost | w_hold_hit;
  assign w_gap_last = (r_gap_cnt == 3'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd0;
      r_hold_cnt   <= 8'd0;
      r_gap_cnt    <= 3'd0;
      r_grant_addr <= 2'd0;
      r_grant_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant_addr <= w_winner;
            r_grant_en   <= 1'b1;
            r_hold_cnt   <= 8'd0;
            r_busy       <= 1'b1;
            r_state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_grant_en <= 1'b0;
            r_ptr      <= r_grant_addr + 2'd1;
            r_gap_cnt  <= 3'd0;
            r_state    <= S_GAP;
            // Timeout is reported only when the hold limit alone ended the grant.
            r_timeout  <= w_hold_hit & ~w_done_own & ~w_req_lost;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (w_gap_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 3'd1;
          end
        end
        default: begin
          r_grant_en <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_addr = r_grant_addr;
  assign grant_en   = r_grant_en;
  assign busy       = r_busy;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter4
//   Directed-vector bench for rr_grant_arbiter4 (MAX_HOLD=15, GAP_CYCLES=1).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, i.e. well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [1:0] grant_addr;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_bad;

  rr_grant_arbiter4 #(.MAX_HOLD(15), .GAP_CYCLES(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant_addr (grant_addr),
    .grant_en   (grant_en),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  // Decoder output seen downstream: one-hot of grant_addr when enabled.
  function automatic int dec_out(input logic en, input logic [1:0] a);
    return en ? (1 << a) : 0;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;

    // Reset state
    do_reset();
    chk("rst_en",   int'(grant_en),   0);
    chk("rst_addr", int'(grant_addr), 0);
    chk("rst_busy", int'(busy),       0);
    chk("rst_tmo",  int'(timeout),    0);

    // T1: single requester 2, granted on the first edge
    req = 4'b0100;
    step();
    chk("t1_en",   int'(grant_en),   1);
    chk("t1_addr", int'(grant_addr), 2);
    chk("t1_dec",  dec_out(grant_en, grant_addr), 4);
    chk("t1_busy", int'(busy),       1);

    // T2: all request, done on 3rd grant cycle; owners 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_en1",   int'(grant_en),   1);
      chk("t2_owner", int'(grant_addr), k % 4);
      step();
      chk("t2_en2",   int'(grant_en),   1);
      step();
      chk("t2_en3",   int'(grant_en),   1);
      done = 4'(1 << (k % 4));
      step();
      done = 4'b0000;
      chk("t2_gap0",  int'(grant_en),   0);
      chk("t2_hold",  int'(grant_addr), k % 4);
      chk("t2_tmo",   int'(timeout),    0);
      step();
      chk("t2_gap1",  int'(grant_en),   0);
      chk("t2_gbusy", int'(busy),       0);
    end

    // T3: owner 3 done, then req=0011 -> owner 0, then ptr=1 picks owner 1
    do_reset();
    req = 4'b1000;
    step();
    chk("t3_own3", int'(grant_addr), 3);
    step();
    done = 4'b1000;
    step();
    done = 4'b0000;
    req  = 4'b0011;
    chk("t3_rel",  int'(grant_en), 0);
    step();
    step();
    chk("t3_en0",  int'(grant_en),   1);
    chk("t3_own0", int'(grant_addr), 0);
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    step();
    chk("t3_en1",  int'(grant_en),   1);
    chk("t3_own1", int'(grant_addr), 1);

    // T4: hold limit on requester 1
    do_reset();
    req = 4'b0010;
    step();
    chk("t4_en_first", int'(grant_en), 1);
    for (int i = 1; i < 15; i++) begin
      step();
      chk("t4_en_hold", int'(grant_en), 1);
      chk("t4_tmo_lo",  int'(timeout),  0);
    end
    step();
    chk("t4_en_off", int'(grant_en), 0);
    chk("t4_tmo",    int'(timeout),  1);
    chk("t4_busy",   int'(busy),     1);
    step();
    chk("t4_tmo_pulse", int'(timeout),  0);
    chk("t4_gap_en",    int'(grant_en), 0);
    step();
    chk("t4_regrant", int'(grant_en),   1);
    chk("t4_own1",    int'(grant_addr), 1);

    // T5a: non-owner done ignored, then owner drops its request
    do_reset();
    req = 4'b0010;
    step();
    done = 4'b0100;
    step();
    done = 4'b0000;
    chk("t5_nonown", int'(grant_en), 1);
    step();
    chk("t5_still",  int'(grant_en), 1);
    req = 4'b0000;
    step();
    chk("t5_drop_en",  int'(grant_en), 0);
    chk("t5_drop_tmo", int'(timeout),  0);

    // T5b: done on the same edge as the hold limit -> no timeout
    do_reset();
    req = 4'b0010;
    step();
    for (int i = 1; i < 15; i++) begin
      step();
    end
    chk("t5b_en_last", int'(grant_en), 1);
    done = 4'b0010;
    step();
    done = 4'b0000;
    chk("t5b_en",  int'(grant_en), 0);
    chk("t5b_tmo", int'(timeout),  0);

    // T6: reset during 4th cycle of a grant to 2
    do_reset();
    req = 4'b0100;
    step();
    chk("t6_own2", int'(grant_addr), 2);
    req = 4'b1111;
    step();
    step();
    step();
    chk("t6_en4", int'(grant_en), 1);
    reset = 1'b1;
    step();
    chk("t6_rst_en",   int'(grant_en),   0);
    chk("t6_rst_busy", int'(busy),       0);
    chk("t6_rst_tmo",  int'(timeout),    0);
    chk("t6_rst_addr", int'(grant_addr), 0);
    reset = 1'b0;
    step();
    chk("t6_en",   int'(grant_en),   1);
    chk("t6_own0", int'(grant_addr), 0);
    step();
    chk("t6_tmo",  int'(timeout),    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
